fmcrop_axi: RTL and testbench

//  Feature-map cropping for AXI-Stream, the inverse of fmpadding_axi. Consumes full frames of XEnd+1 x YEnd+1

---
 rtl/fmcrop_pkg.sv | 28 ++
 rtl/fmcrop_cfg_axilite.sv | 124 ++++++++++++
 rtl/fmcrop_axi.sv | 158 +++++++++++++++
 tb/tb_fmcrop_axi.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmcrop_pkg.sv
// Shared definitions for the feature-map crop block: register map, crop window
// record and the beats-per-pixel helper.
package fmcrop_pkg;

    // Width of every stored window field; counters narrower than this are zero-extended.
    localparam int CFG_W = 16;

    localparam logic [2:0] ADDR_XON  = 3'd0;
    localparam logic [2:0] ADDR_XOFF = 3'd1;
    localparam logic [2:0] ADDR_XEND = 3'd2;
    localparam logic [2:0] ADDR_YON  = 3'd4;
    localparam logic [2:0] ADDR_YOFF = 3'd5;
    localparam logic [2:0] ADDR_YEND = 3'd6;

    typedef struct packed {
        logic [CFG_W-1:0] x_on;
        logic [CFG_W-1:0] x_off;
        logic [CFG_W-1:0] x_end;
        logic [CFG_W-1:0] y_on;
        logic [CFG_W-1:0] y_off;
        logic [CFG_W-1:0] y_end;
    } cfg_t;

    function automatic int nf(input int num_channels, input int simd);
        return num_channels / simd;
    endfunction

endpackage

// File: rtl/fmcrop_cfg_axilite.sv
// AXI-Lite slave holding the shadow copy of the crop window. AW and W are
// captured independently; the shadow register is written once both are held.
module fmcrop_cfg_axilite
    import fmcrop_pkg::*;
#(
    parameter int XCOUNTER_BITS = 8,
    parameter int YCOUNTER_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axilite_AWVALID,
    output logic        s_axilite_AWREADY,
    input  logic [2:0]  s_axilite_AWADDR,
    input  logic        s_axilite_WVALID,
    output logic        s_axilite_WREADY,
    input  logic [31:0] s_axilite_WDATA,
    input  logic [3:0]  s_axilite_WSTRB,
    output logic        s_axilite_BVALID,
    input  logic        s_axilite_BREADY,
    output logic [1:0]  s_axilite_BRESP,
    input  logic        s_axilite_ARVALID,
    output logic        s_axilite_ARREADY,
    input  logic [2:0]  s_axilite_ARADDR,
    output logic        s_axilite_RVALID,
    input  logic        s_axilite_RREADY,
    output logic [31:0] s_axilite_RDATA,
    output logic [1:0]  s_axilite_RRESP,
    output cfg_t        cfg
);

    localparam logic [CFG_W-1:0] XMASK = CFG_W'((32'd1 << XCOUNTER_BITS) - 32'd1);
    localparam logic [CFG_W-1:0] YMASK = CFG_W'((32'd1 << YCOUNTER_BITS) - 32'd1);

    logic             alive;
    logic             aw_held;
    logic             w_held;
    logic [2:0]       aw_addr_q;
    logic [31:0]      w_data_q;
    logic             bvalid_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [CFG_W-1:0] rd_val;
    logic [CFG_W-1:0] wr_x;
    logic [CFG_W-1:0] wr_y;
    cfg_t             shadow;

    // Strobes are ignored and data above the stored width is truncated.
    logic unused_bits;
    assign unused_bits = ^{s_axilite_WSTRB, w_data_q[31:CFG_W]};

    // alive keeps every ready low while rst is held and for the first edge after.
    assign s_axilite_AWREADY = alive & ~aw_held & ~bvalid_q;
    assign s_axilite_WREADY  = alive & ~w_held & ~bvalid_q;
    assign s_axilite_BVALID  = bvalid_q;
    assign s_axilite_BRESP   = 2'b00;
    assign s_axilite_ARREADY = alive & ~rvalid_q;
    assign s_axilite_RVALID  = rvalid_q;
    assign s_axilite_RDATA   = rdata_q;
    assign s_axilite_RRESP   = 2'b00;
    assign cfg               = shadow;

    assign wr_x = w_data_q[CFG_W-1:0] & XMASK;
    assign wr_y = w_data_q[CFG_W-1:0] & YMASK;

    always_comb begin
        rd_val = '0;
        case (s_axilite_ARADDR)
            ADDR_XON:  rd_val = shadow.x_on;
            ADDR_XOFF: rd_val = shadow.x_off;
            ADDR_XEND: rd_val = shadow.x_end;
            ADDR_YON:  rd_val = shadow.y_on;
            ADDR_YOFF: rd_val = shadow.y_off;
            ADDR_YEND: rd_val = shadow.y_end;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive     <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            shadow    <= '0;
        end else begin
            alive <= 1'b1;
            if (s_axilite_AWVALID && s_axilite_AWREADY) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axilite_AWADDR;
            end
            if (s_axilite_WVALID && s_axilite_WREADY) begin
                w_held   <= 1'b1;
                w_data_q <= s_axilite_WDATA;
            end
            if (aw_held && w_held) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                case (aw_addr_q)
                    ADDR_XON:  shadow.x_on  <= wr_x;
                    ADDR_XOFF: shadow.x_off <= wr_x;
                    ADDR_XEND: shadow.x_end <= wr_x;
                    ADDR_YON:  shadow.y_on  <= wr_y;
                    ADDR_YOFF: shadow.y_off <= wr_y;
                    ADDR_YEND: shadow.y_end <= wr_y;
                    default:   ;
                endcase
            end else if (bvalid_q && s_axilite_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (s_axilite_ARVALID && s_axilite_ARREADY) begin
                rvalid_q <= 1'b1;
                rdata_q  <= 32'(rd_val);
            end else if (rvalid_q && s_axilite_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fmcrop_axi.sv
// AXI-Stream feature-map crop: walks every beat of the incoming frame and forwards
// only those inside the active window through a 2-entry skid buffer.
module fmcrop_axi
    import fmcrop_pkg::*;
#(
    parameter int XCOUNTER_BITS = 8,
    parameter int YCOUNTER_BITS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SIMD          = 2,
    parameter int ELEM_BITS     = 4,
    localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_axilite_AWVALID,
    output logic                   s_axilite_AWREADY,
    input  logic [2:0]             s_axilite_AWADDR,
    input  logic                   s_axilite_WVALID,
    output logic                   s_axilite_WREADY,
    input  logic [31:0]            s_axilite_WDATA,
    input  logic [3:0]             s_axilite_WSTRB,
    output logic                   s_axilite_BVALID,
    input  logic                   s_axilite_BREADY,
    output logic [1:0]             s_axilite_BRESP,
    input  logic                   s_axilite_ARVALID,
    output logic                   s_axilite_ARREADY,
    input  logic [2:0]             s_axilite_ARADDR,
    output logic                   s_axilite_RVALID,
    input  logic                   s_axilite_RREADY,
    output logic [31:0]            s_axilite_RDATA,
    output logic [1:0]             s_axilite_RRESP,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [STREAM_BITS-1:0] m_axis_tdata
);

    localparam int NF = nf(NUM_CHANNELS, SIMD);
    localparam int SW = (NF > 1) ? $clog2(NF) : 1;

    cfg_t                   shadow;
    cfg_t                   act;
    logic [SW-1:0]          s;
    logic [XCOUNTER_BITS-1:0] x;
    logic [YCOUNTER_BITS-1:0] y;
    logic [CFG_W-1:0]       x_ext;
    logic [CFG_W-1:0]       y_ext;
    logic                   accept;
    logic                   at_origin;
    logic                   keep;
    logic                   push;
    logic                   pop;
    logic                   tready_q;
    logic [STREAM_BITS-1:0] skid_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic [1:0]             count_nxt;

    fmcrop_cfg_axilite #(
        .XCOUNTER_BITS (XCOUNTER_BITS),
        .YCOUNTER_BITS (YCOUNTER_BITS)
    ) u_cfg (
        .clk               (clk),
        .rst               (rst),
        .s_axilite_AWVALID (s_axilite_AWVALID),
        .s_axilite_AWREADY (s_axilite_AWREADY),
        .s_axilite_AWADDR  (s_axilite_AWADDR),
        .s_axilite_WVALID  (s_axilite_WVALID),
        .s_axilite_WREADY  (s_axilite_WREADY),
        .s_axilite_WDATA   (s_axilite_WDATA),
        .s_axilite_WSTRB   (s_axilite_WSTRB),
        .s_axilite_BVALID  (s_axilite_BVALID),
        .s_axilite_BREADY  (s_axilite_BREADY),
        .s_axilite_BRESP   (s_axilite_BRESP),
        .s_axilite_ARVALID (s_axilite_ARVALID),
        .s_axilite_ARREADY (s_axilite_ARREADY),
        .s_axilite_ARADDR  (s_axilite_ARADDR),
        .s_axilite_RVALID  (s_axilite_RVALID),
        .s_axilite_RREADY  (s_axilite_RREADY),
        .s_axilite_RDATA   (s_axilite_RDATA),
        .s_axilite_RRESP   (s_axilite_RRESP),
        .cfg               (shadow)
    );

    assign x_ext     = CFG_W'(x);
    assign y_ext     = CFG_W'(y);
    assign accept    = s_axis_tvalid & tready_q;
    assign at_origin = (s == '0) && (x == '0) && (y == '0);
    // Window test uses the position of the beat being accepted, before it advances.
    assign keep      = (x_ext >= act.x_on) && (x_ext < act.x_off) &&
                       (y_ext >= act.y_on) && (y_ext < act.y_off);
    assign push      = accept & keep;
    assign pop       = m_axis_tvalid & m_axis_tready;

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = skid_mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Stage p0: position counters and frame-boundary config load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s   <= '0;
            x   <= '0;
            y   <= '0;
            act <= '0;
        end else begin
            // Idle at the origin is the only safe moment to swap the window.
            if (at_origin && !accept)
                act <= shadow;
            if (accept) begin
                if (s == SW'(NF - 1)) begin
                    s <= '0;
                    if (x_ext == act.x_end) begin
                        x <= '0;
                        y <= (y_ext == act.y_end) ? '0 : y + YCOUNTER_BITS'(1);
                    end else begin
                        x <= x + XCOUNTER_BITS'(1);
                    end
                end else begin
                    s <= s + SW'(1);
                end
            end
        end
    end

    // Stage p1: skid buffer control; tready is registered so m_axis_tready never reaches it combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            tready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count    <= count_nxt;
            tready_q <= (count_nxt != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            skid_mem[wr_ptr] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_fmcrop_axi.sv
// Directed bench for fmcrop_axi: table of crop windows over full frames plus
// hand-written sequences for stalls, mid-frame rewrites, readback and reset.
module tb_fmcrop_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_axilite_AWVALID = 1'b0, s_axilite_AWREADY;
    logic [2:0]  s_axilite_AWADDR = '0;
    logic        s_axilite_WVALID = 1'b0, s_axilite_WREADY;
    logic [31:0] s_axilite_WDATA = '0;
    logic [3:0]  s_axilite_WSTRB = 4'hF;
    logic        s_axilite_BVALID, s_axilite_BREADY = 1'b0;
    logic [1:0]  s_axilite_BRESP;
    logic        s_axilite_ARVALID = 1'b0, s_axilite_ARREADY;
    logic [2:0]  s_axilite_ARADDR = '0;
    logic        s_axilite_RVALID, s_axilite_RREADY = 1'b0;
    logic [31:0] s_axilite_RDATA;
    logic [1:0]  s_axilite_RRESP;
    logic        s_axis_tvalid = 1'b0, s_axis_tready;
    logic [7:0]  s_axis_tdata = '0;
    logic        m_axis_tvalid, m_axis_tready = 1'b1;
    logic [7:0]  m_axis_tdata;

    int total = 0;
    int bad = 0;
    logic [7:0] got[$];
    bit stall_en = 1'b0;
    int stall_cnt = 0;
    bit mon_en = 1'b0;
    int low_run = 0;
    int max_low = 0;

    typedef struct {
        int xon, xoff, xend, yon, yoff, yend;
        int cnt, k, e0, ek, elast;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    fmcrop_axi dut (
        .clk               (clk),
        .rst               (rst),
        .s_axilite_AWVALID (s_axilite_AWVALID),
        .s_axilite_AWREADY (s_axilite_AWREADY),
        .s_axilite_AWADDR  (s_axilite_AWADDR),
        .s_axilite_WVALID  (s_axilite_WVALID),
        .s_axilite_WREADY  (s_axilite_WREADY),
        .s_axilite_WDATA   (s_axilite_WDATA),
        .s_axilite_WSTRB   (s_axilite_WSTRB),
        .s_axilite_BVALID  (s_axilite_BVALID),
        .s_axilite_BREADY  (s_axilite_BREADY),
        .s_axilite_BRESP   (s_axilite_BRESP),
        .s_axilite_ARVALID (s_axilite_ARVALID),
        .s_axilite_ARREADY (s_axilite_ARREADY),
        .s_axilite_ARADDR  (s_axilite_ARADDR),
        .s_axilite_RVALID  (s_axilite_RVALID),
        .s_axilite_RREADY  (s_axilite_RREADY),
        .s_axilite_RDATA   (s_axilite_RDATA),
        .s_axilite_RRESP   (s_axilite_RRESP),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tdata      (m_axis_tdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Output sink with optional 1-3 cycle stalls; also tracks input tready low runs.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                m_axis_tready = 1'b0;
                stall_cnt--;
            end else begin
                m_axis_tready = 1'b1;
                if (stall_en && $urandom_range(0, 3) == 0)
                    stall_cnt = $urandom_range(1, 3);
            end
            if (m_axis_tvalid && m_axis_tready)
                got.push_back(m_axis_tdata);
            if (mon_en) begin
                if (!s_axis_tready) low_run++;
                else low_run = 0;
                if (low_run > max_low) max_low = low_run;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic axil_write(input logic [2:0] a, input logic [31:0] d);
        int t = 0;
        bit aw_go, w_go;
        @(negedge clk);
        s_axilite_AWVALID = 1'b1; s_axilite_AWADDR = a;
        s_axilite_WVALID  = 1'b1; s_axilite_WDATA  = d;
        while ((s_axilite_AWVALID || s_axilite_WVALID) && t < 50) begin
            aw_go = s_axilite_AWVALID && s_axilite_AWREADY;
            w_go  = s_axilite_WVALID && s_axilite_WREADY;
            @(negedge clk);
            t++;
            if (aw_go) s_axilite_AWVALID = 1'b0;
            if (w_go)  s_axilite_WVALID  = 1'b0;
        end
        if (s_axilite_AWVALID || s_axilite_WVALID) begin
            expire("axil aw/w");
            s_axilite_AWVALID = 1'b0;
            s_axilite_WVALID  = 1'b0;
        end
        s_axilite_BREADY = 1'b1;
        t = 0;
        while (!s_axilite_BVALID && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_axilite_BVALID) expire("axil bvalid");
        else check("bresp", 32'(s_axilite_BRESP), 32'd0);
        @(negedge clk);
        s_axilite_BREADY = 1'b0;
    endtask

    task automatic axil_read(input logic [2:0] a, output logic [31:0] d);
        int t = 0;
        d = 'x;
        @(negedge clk);
        s_axilite_ARVALID = 1'b1; s_axilite_ARADDR = a;
        while (!s_axilite_ARREADY && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_axilite_ARREADY) begin
            expire("axil arready");
            s_axilite_ARVALID = 1'b0;
            return;
        end
        @(negedge clk);
        s_axilite_ARVALID = 1'b0;
        s_axilite_RREADY  = 1'b1;
        t = 0;
        while (!s_axilite_RVALID && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_axilite_RVALID) expire("axil rvalid");
        else d = s_axilite_RDATA;
        @(negedge clk);
        s_axilite_RREADY = 1'b0;
    endtask

    task automatic configure(input vec_t v);
        axil_write(3'd0, 32'(v.xon));
        axil_write(3'd1, 32'(v.xoff));
        axil_write(3'd2, 32'(v.xend));
        axil_write(3'd4, 32'(v.yon));
        axil_write(3'd5, 32'(v.yoff));
        axil_write(3'd6, 32'(v.yend));
    endtask

    // Sends n beats whose data is the frame-relative beat index; valid never drops while pending.
    task automatic send(input int n, input int flen, input bit gaps);
        int i = 0;
        int t = 0;
        bit pend = 1'b0;
        while (i < n && t < 20000) begin
            @(negedge clk);
            t++;
            if (!pend) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    s_axis_tvalid = 1'b0;
                end else begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = 8'(i % flen);
                    pend = 1'b1;
                end
            end
            if (pend && s_axis_tready) begin
                i++;
                pend = 1'b0;
            end
        end
        if (i < n) expire("send");
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int exp_q[$];
        int flen;

        vecs[0] = '{xon:2, xoff:7,  xend:9, yon:1, yoff:5, yend:6, cnt:40, k:10, e0:'h18, ek:'h2C, elast:'h5D};
        vecs[1] = '{xon:5, xoff:5,  xend:9, yon:0, yoff:7, yend:6, cnt:0,  k:0,  e0:0,    ek:0,    elast:0};
        vecs[2] = '{xon:8, xoff:15, xend:9, yon:0, yoff:7, yend:6, cnt:28, k:4,  e0:'h10, ek:'h24, elast:'h8B};
        vecs[3] = '{xon:0, xoff:1,  xend:0, yon:2, yoff:4, yend:6, cnt:4,  k:2,  e0:'h04, ek:'h06, elast:'h07};

        // reset state
        repeat (3) @(negedge clk);
        check("rst s_tready", 32'(s_axis_tready), 32'd0);
        check("rst m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst awready", 32'(s_axilite_AWREADY), 32'd0);
        check("rst wready", 32'(s_axilite_WREADY), 32'd0);
        check("rst arready", 32'(s_axilite_ARREADY), 32'd0);
        check("rst bvalid", 32'(s_axilite_BVALID), 32'd0);
        check("rst rvalid", 32'(s_axilite_RVALID), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post-rst s_tready", 32'(s_axis_tready), 32'd1);
        axil_read(3'd1, rd);
        check("post-rst xoff", rd, 32'd0);

        // table of windows, one full frame each
        for (int v = 0; v < 4; v++) begin
            configure(vecs[v]);
            flen = (vecs[v].xend + 1) * (vecs[v].yend + 1) * 2;
            got.delete();
            max_low = 0;
            low_run = 0;
            mon_en  = (vecs[v].cnt == 0);
            send(flen, flen, 1'b0);
            wait_out(vecs[v].cnt);
            mon_en = 1'b0;
            check($sformatf("vec%0d count", v), 32'(got.size()), 32'(vecs[v].cnt));
            if (vecs[v].cnt == 0) begin
                check($sformatf("vec%0d tready gap<=1", v), 32'(max_low <= 1), 32'd1);
            end else if (got.size() == vecs[v].cnt) begin
                check($sformatf("vec%0d first", v), 32'(got[0]), 32'(vecs[v].e0));
                check($sformatf("vec%0d second", v), 32'(got[1]), 32'(vecs[v].e0 + 1));
                check($sformatf("vec%0d beat k", v), 32'(got[vecs[v].k]), 32'(vecs[v].ek));
                check($sformatf("vec%0d last", v), 32'(got[vecs[v].cnt-1]), 32'(vecs[v].elast));
            end
        end

        // two back-to-back frames with input gaps and output stalls
        configure(vecs[0]);
        got.delete();
        stall_en = 1'b1;
        send(280, 140, 1'b1);
        wait_out(80);
        stall_en = 1'b0;
        wait_out(80);
        exp_q.delete();
        for (int f = 0; f < 2; f++)
            for (int yy = 0; yy < 7; yy++)
                for (int xx = 0; xx < 10; xx++)
                    for (int ss = 0; ss < 2; ss++)
                        if (xx >= 2 && xx < 7 && yy >= 1 && yy < 5)
                            exp_q.push_back((yy * 10 + xx) * 2 + ss);
        check("stall count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size())
                check($sformatf("stall beat%0d", i), 32'(got[i]), 32'(exp_q[i]));

        // XOn rewritten mid-frame: only the next frame may see it
        got.delete();
        fork
            begin
                send(140, 140, 1'b0);
                send(140, 140, 1'b0);
            end
            begin
                repeat (40) @(negedge clk);
                axil_write(3'd0, 32'd0);
            end
        join
        wait_out(96);
        check("rewrite count", 32'(got.size()), 32'd96);
        if (got.size() == 96) begin
            check("rewrite f1 first", 32'(got[0]), 32'h18);
            check("rewrite f1 last", 32'(got[39]), 32'h5D);
            check("rewrite f2 first", 32'(got[40]), 32'h14);
            check("rewrite f2 row2", 32'(got[54]), 32'h28);
            check("rewrite f2 last", 32'(got[95]), 32'h5D);
        end

        // register readback and truncation
        axil_write(3'd5, 32'h1234);
        axil_read(3'd5, rd);
        check("read yoff", rd, 32'h34);
        axil_read(3'd3, rd);
        check("read addr3", rd, 32'd0);
        axil_write(3'd3, 32'hAB);
        axil_read(3'd3, rd);
        check("read addr3 after write", rd, 32'd0);
        axil_read(3'd1, rd);
        check("read xoff", rd, 32'd7);
        axil_read(3'd0, rd);
        check("read xon", rd, 32'd0);

        // reset mid-frame, then reconfigure and rerun
        configure(vecs[0]);
        got.delete();
        send(57, 140, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst s_tready", 32'(s_axis_tready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        got.delete();
        axil_read(3'd2, rd);
        check("midrst xend cleared", rd, 32'd0);
        configure(vecs[0]);
        send(140, 140, 1'b0);
        wait_out(40);
        check("restart count", 32'(got.size()), 32'd40);
        if (got.size() == 40) begin
            check("restart first", 32'(got[0]), 32'h18);
            check("restart beat10", 32'(got[10]), 32'h2C);
            check("restart last", 32'(got[39]), 32'h5D);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
